// File: rtl/sap1_controlador_sequenciador_ucode_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sap1_controlador_sequenciador_ucode_if                          |
// | Brief    : Switch inputs and control-word outputs of the SAP-1 controller. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface sap1_controlador_sequenciador_ucode_if #(
    parameter int CNT_W = 8
);
    logic             run;
    logic             step_mode;
    logic             step;
    logic [3:0]       op;
    logic [5:0]       t;
    logic             n_hlt;
    logic             cp;
    logic             ep;
    logic             ea;
    logic             su;
    logic             eu;
    logic             n_lm;
    logic             n_ce;
    logic             n_l1;
    logic             n_e1;
    logic             n_la;
    logic             n_lb;
    logic             n_l0;
    logic             instr_done;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output run, step_mode, step, op,
        input  t, n_hlt, cp, ep, ea, su, eu,
        input  n_lm, n_ce, n_l1, n_e1, n_la, n_lb, n_l0,
        input  instr_done, instr_count
    );

    modport slave (
        input  run, step_mode, step, op,
        output t, n_hlt, cp, ep, ea, su, eu,
        output n_lm, n_ce, n_l1, n_e1, n_la, n_lb, n_l0,
        output instr_done, instr_count
    );
endinterface
`default_nettype wire

// File: rtl/sap1_controlador_sequenciador_ucode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sap1_controlador_sequenciador_ucode                             |
// | Brief    : SAP-1 ring-counter sequencer and opcode decoder with run/pause, |
// |            single-instruction stepping and a retired-instruction counter.  |
// |            Define SAP1_EARLY_END_EN for a variable-length machine cycle.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module sap1_controlador_sequenciador_ucode #(
    parameter int         CNT_W  = 8,
    parameter logic [3:0] OP_LDA = 4'h0,
    parameter logic [3:0] OP_ADD = 4'h1,
    parameter logic [3:0] OP_SUB = 4'h2,
    parameter logic [3:0] OP_OUT = 4'hE,
    parameter logic [3:0] OP_HLT = 4'hF
) (
    input  wire logic                               clk,
    input  wire logic                               clr,
    sap1_controlador_sequenciador_ucode_if.slave    bus
);

    typedef enum logic [5:0] {
        S_T1 = 6'b000001,
        S_T2 = 6'b000010,
        S_T3 = 6'b000100,
        S_T4 = 6'b001000,
        S_T5 = 6'b010000,
        S_T6 = 6'b100000
    } t_state_e;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    t_state_e         r_state;
    t_state_e         w_state_nxt;
    logic             r_halted;
    logic             w_halted_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;

    logic w_is_lda;
    logic w_is_add;
    logic w_is_sub;
    logic w_is_out;
    logic w_is_hlt;
    logic w_is_alu;
    logic w_step_wait;
    logic w_active;
    logic w_last;
    logic w_done;

    assign w_is_lda = (bus.op == OP_LDA);
    assign w_is_add = (bus.op == OP_ADD);
    assign w_is_sub = (bus.op == OP_SUB);
    assign w_is_out = (bus.op == OP_OUT);
    assign w_is_hlt = (bus.op == OP_HLT);
    assign w_is_alu = w_is_add || w_is_sub;

    // In step mode T1 is a parking state until a step request is seen there.
    assign w_step_wait = bus.step_mode && (r_state == S_T1) && !bus.step;
    assign w_active    = !clr && bus.run && !r_halted && !w_step_wait;

`ifdef SAP1_EARLY_END_EN
    always_comb begin
        w_last = 1'b0;
        if (w_is_lda) begin
            w_last = (r_state == S_T5);
        end else if (w_is_alu || w_is_hlt) begin
            w_last = (r_state == S_T6);
        end else if (w_is_out) begin
            w_last = (r_state == S_T4);
        end else begin
            w_last = (r_state == S_T3);
        end
    end
`else
    always_comb begin
        w_last = (r_state == S_T6);
    end
`endif

    assign w_done = w_active && w_last && !w_is_hlt;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state  <= S_T1;
            r_halted <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_halted <= w_halted_nxt;
            r_count  <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_halted_nxt = r_halted;
        w_count_nxt  = r_count;
        if (w_active) begin
            if ((r_state == S_T4) && w_is_hlt) begin
                w_halted_nxt = 1'b1;
            end else if (w_done) begin
                w_state_nxt = S_T1;
                w_count_nxt = r_count + c_CNT_ONE;
            end else begin
                case (r_state)
                    S_T1:    w_state_nxt = S_T2;
                    S_T2:    w_state_nxt = S_T3;
                    S_T3:    w_state_nxt = S_T4;
                    S_T4:    w_state_nxt = S_T5;
                    S_T5:    w_state_nxt = S_T6;
                    default: w_state_nxt = S_T1;
                endcase
            end
        end
    end

    logic w_cp, w_ep, w_ea, w_su, w_eu;
    logic w_n_lm, w_n_ce, w_n_l1, w_n_e1, w_n_la, w_n_lb, w_n_l0;

    always_comb begin
        w_cp   = 1'b0;
        w_ep   = 1'b0;
        w_ea   = 1'b0;
        w_su   = 1'b0;
        w_eu   = 1'b0;
        w_n_lm = 1'b1;
        w_n_ce = 1'b1;
        w_n_l1 = 1'b1;
        w_n_e1 = 1'b1;
        w_n_la = 1'b1;
        w_n_lb = 1'b1;
        w_n_l0 = 1'b1;
        if (w_active) begin
            case (r_state)
                S_T1: begin
                    w_ep   = 1'b1;
                    w_n_lm = 1'b0;
                end
                S_T2: w_cp = 1'b1;
                S_T3: begin
                    w_n_ce = 1'b0;
                    w_n_l1 = 1'b0;
                end
                S_T4: begin
                    if (w_is_lda || w_is_alu) begin
                        w_n_e1 = 1'b0;
                        w_n_lm = 1'b0;
                    end else if (w_is_out) begin
                        w_ea   = 1'b1;
                        w_n_l0 = 1'b0;
                    end
                end
                S_T5: begin
                    if (w_is_lda) begin
                        w_n_ce = 1'b0;
                        w_n_la = 1'b0;
                    end else if (w_is_alu) begin
                        w_n_ce = 1'b0;
                        w_n_lb = 1'b0;
                    end
                end
                S_T6: begin
                    if (w_is_alu) begin
                        w_eu   = 1'b1;
                        w_n_la = 1'b0;
                    end
                end
                default: ;
            endcase
            // su leads eu by two states so the adder output is settled when driven.
            if (w_is_sub && ((r_state == S_T4) || (r_state == S_T5) || (r_state == S_T6))) begin
                w_su = 1'b1;
            end
        end
    end

    assign bus.cp          = w_cp;
    assign bus.ep          = w_ep;
    assign bus.ea          = w_ea;
    assign bus.su          = w_su;
    assign bus.eu          = w_eu;
    assign bus.n_lm        = w_n_lm;
    assign bus.n_ce        = w_n_ce;
    assign bus.n_l1        = w_n_l1;
    assign bus.n_e1        = w_n_e1;
    assign bus.n_la        = w_n_la;
    assign bus.n_lb        = w_n_lb;
    assign bus.n_l0        = w_n_l0;
    assign bus.t           = clr ? S_T1 : r_state;
    assign bus.n_hlt       = clr ? 1'b1 :
                             !(r_halted || (w_active && (r_state == S_T4) && w_is_hlt));
    assign bus.instr_done  = w_done;
    assign bus.instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_sap1_controlador_sequenciador_ucode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sap1_controlador_sequenciador_ucode                          |
// | Brief    : Directed and random bench with a phase-level reference model.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_sap1_controlador_sequenciador_ucode;

    localparam logic [11:0] c_INACT = 12'b00000_1111111;

    logic clk = 1'b0;
    logic clr;
    int   errors = 0;
    int   checks = 0;

    int   m_ph;
    bit   m_halted;
    int   m_cnt;

    sap1_controlador_sequenciador_ucode_if #(.CNT_W(8)) bus ();

    sap1_controlador_sequenciador_ucode #(.CNT_W(8)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Expected control word, packed {cp,ep,ea,su,eu,n_lm,n_ce,n_l1,n_e1,n_la,n_lb,n_l0}.
    function automatic logic [11:0] word(int ph, logic [3:0] op);
        bit cp = 0, ep = 0, ea = 0, su = 0, eu = 0;
        bit lm = 0, ce = 0, l1 = 0, e1 = 0, la = 0, lb = 0, l0 = 0;
        case (ph)
            1: begin ep = 1; lm = 1; end
            2: cp = 1;
            3: begin ce = 1; l1 = 1; end
            default: begin
                if (op == 4'h0 || op == 4'h1 || op == 4'h2) begin
                    if (ph == 4) begin e1 = 1; lm = 1; end
                    if (ph == 5) begin
                        ce = 1;
                        if (op == 4'h0) la = 1; else lb = 1;
                    end
                    if (ph == 6 && op != 4'h0) begin eu = 1; la = 1; end
                    su = (op == 4'h2);
                end else if (op == 4'hE && ph == 4) begin
                    ea = 1; l0 = 1;
                end
            end
        endcase
        return {cp, ep, ea, su, eu, ~lm, ~ce, ~l1, ~e1, ~la, ~lb, ~l0};
    endfunction

    function automatic int last_ph(logic [3:0] op);
`ifdef SAP1_EARLY_END_EN
        case (op)
            4'h0:       return 5;
            4'h1, 4'h2: return 6;
            4'hE:       return 4;
            4'hF:       return 6;
            default:    return 3;
        endcase
`else
        return 6;
`endif
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: predict outputs from the model and current inputs, compare, then advance the model.
    task automatic cycle();
        logic [11:0] e_word;
        logic [5:0]  e_t;
        bit          e_nhlt, e_done, w8, act;
        int          nph, nc;
        bit          nh;
        if (clr) begin
            e_word = c_INACT; e_nhlt = 1; e_done = 0; e_t = 6'b000001;
            nph = 1; nh = 0; nc = 0;
        end else begin
            w8     = bus.step_mode && m_ph == 1 && !bus.step;
            act    = bus.run && !m_halted && !w8;
            e_t    = 6'(1 << (m_ph - 1));
            e_word = act ? word(m_ph, bus.op) : c_INACT;
            e_nhlt = !(m_halted || (act && m_ph == 4 && bus.op == 4'hF));
            e_done = act && m_ph == last_ph(bus.op) && bus.op != 4'hF;
            nph = m_ph; nh = m_halted; nc = m_cnt;
            if (act) begin
                if (m_ph == 4 && bus.op == 4'hF) nh = 1;
                else if (e_done) begin nph = 1; nc = (m_cnt + 1) % 256; end
                else nph = m_ph + 1;
            end
        end
        #2;
        chk("t", 32'(bus.t), 32'(e_t));
        chk("word", 32'({bus.cp, bus.ep, bus.ea, bus.su, bus.eu, bus.n_lm, bus.n_ce,
                         bus.n_l1, bus.n_e1, bus.n_la, bus.n_lb, bus.n_l0}), 32'(e_word));
        chk("n_hlt", 32'(bus.n_hlt), 32'(e_nhlt));
        chk("instr_done", 32'(bus.instr_done), 32'(e_done));
        if (!clr) chk("instr_count", 32'(bus.instr_count), 32'(m_cnt));
        @(posedge clk);
        m_ph = nph; m_halted = nh; m_cnt = nc;
        @(negedge clk);
    endtask

    task automatic run_instr(logic [3:0] op);
        int guard;
        bus.op = op;
        cycle();
        guard = 0;
        while (m_ph != 1 && guard < 20) begin
            cycle();
            guard++;
        end
        chk("instr_bound", 32'(guard < 20), 32'd1);
    endtask

    initial begin
        int guard;
        m_ph = 1; m_halted = 0; m_cnt = 0;
        clr = 1'b1; bus.run = 1'b0; bus.step_mode = 1'b0; bus.step = 1'b0; bus.op = 4'h0;
        @(negedge clk);

        // Clear for two cycles.
        cycle(); cycle();
        clr = 1'b0;
        chk("clr_count", 32'(bus.instr_count), 32'd0);

        // LDA then SUB.
        bus.run = 1'b1;
        run_instr(4'h0);
        chk("lda_count", 32'(bus.instr_count), 32'd1);
        run_instr(4'h2);
        chk("sub_count", 32'(bus.instr_count), 32'd2);

        // HLT: freeze at T4, then clear.
        bus.op = 4'hF;
        repeat (14) cycle();
        chk("hlt_t", 32'(bus.t), 32'h08);
        chk("hlt_count", 32'(bus.instr_count), 32'd2);
        clr = 1'b1; cycle(); clr = 1'b0;

        // Pause at T3.
        bus.op = 4'h1;
        cycle(); cycle();
        bus.run = 1'b0;
        repeat (3) cycle();
        chk("pause_t", 32'(bus.t), 32'h04);
        bus.run = 1'b1;
        guard = 0;
        while (m_ph != 1 && guard < 20) begin cycle(); guard++; end

        // Single stepping.
        bus.step_mode = 1'b1; bus.op = 4'h0;
        repeat (5) cycle();
        bus.step = 1'b1; cycle(); bus.step = 1'b0;
        guard = 0;
        while (m_ph != 1 && guard < 20) begin cycle(); guard++; end
        repeat (3) cycle();
        chk("step_park_t", 32'(bus.t), 32'h01);
        bus.step_mode = 1'b0;

        // Drive the counter to 255 with NOPs, then wrap.
        bus.op = 4'h5;
        guard = 0;
        while (m_cnt != 255 && guard < 3000) begin cycle(); guard++; end
        chk("cnt255", 32'(bus.instr_count), 32'd255);
        run_instr(4'h5);
        chk("wrap", 32'(bus.instr_count), 32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            clr = ($urandom_range(0, 63) == 0) || (m_halted && $urandom_range(0, 3) == 0);
            bus.run = ($urandom_range(0, 7) != 0);
            if (m_ph == 1) begin
                case ($urandom_range(0, 9))
                    0, 1:    bus.op = 4'h0;
                    2, 3:    bus.op = 4'h1;
                    4, 5:    bus.op = 4'h2;
                    6:       bus.op = 4'hE;
                    7:       bus.op = 4'hF;
                    default: bus.op = 4'($urandom_range(3, 13));
                endcase
                bus.step_mode = ($urandom_range(0, 3) == 0);
            end
            bus.step = ($urandom_range(0, 2) == 0);
            cycle();
        end
        clr = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
